life_frame_streamer: RTL and testbench

//   Reader side of the Game of Life grid. On request, walks the grid row by row

---
 rtl/life_frame_streamer.sv | 116 +++++++++++
 tb/tb_life_frame_streamer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_frame_streamer.sv
// Frame reader for the Life grid: fetches one row at a time over a synchronous
// row-read port and streams it out as WORD_W-bit words on a valid/ready link.
module life_frame_streamer #(
  parameter int WIDTH  = 1200,
  parameter int HEIGHT = 1920,
  parameter int WORD_W = 32
) (
  input  logic                                           clk,
  input  logic                                           reset_n,
  input  logic                                           start,
  output logic                                           busy,
  output logic                                           hold_gen,
  output logic                                           row_rd,
  output logic [((HEIGHT > 1) ? $clog2(HEIGHT) : 1)-1:0] row_addr,
  input  logic [WIDTH-1:0]                               row_data,
  output logic [WORD_W-1:0]                              out_data,
  output logic                                           out_valid,
  input  logic                                           out_ready,
  output logic                                           out_sof,
  output logic                                           out_eol,
  output logic                                           out_eof,
  output logic                                           frame_done
);

  localparam int WPR = (WIDTH + WORD_W - 1) / WORD_W;
  localparam int AW  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int KW  = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int PW  = WPR * WORD_W;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [AW-1:0] ROW_LAST = AW'(HEIGHT - 1);
  localparam logic [KW-1:0] K_LAST   = KW'(WPR - 1);

  logic [2:0]       state_q, state_d;
  logic [AW-1:0]    row_q, row_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] rowbuf_q;
  logic [PW-1:0]    rowbuf_pad;
  logic             send;

  assign send = (state_q == S_SEND);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          row_d   = '0;
          k_d     = '0;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        k_d     = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (out_ready) begin
          if (k_q != K_LAST) begin
            k_d = k_q + KW'(1);
          end else if (row_q != ROW_LAST) begin
            row_d   = row_q + AW'(1);
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        row_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      k_q     <= k_d;
    end
  end

  // Row buffer is pure data: only the control path needs a reset.
  always_ff @(posedge clk) begin
    if (state_q == S_LOAD) rowbuf_q <= row_data;
  end

  // Zero-extend so the tail of the last word reads as 0 past WIDTH.
  assign rowbuf_pad = PW'(rowbuf_q);

  assign busy       = (state_q != S_IDLE);
  assign hold_gen   = busy;
  assign row_rd     = (state_q == S_FETCH);
  assign row_addr   = row_rd ? row_q : '0;
  assign out_valid  = send;
  assign out_data   = send ? rowbuf_pad[int'(k_q) * WORD_W +: WORD_W] : '0;
  assign out_sof    = send && (row_q == '0) && (k_q == '0);
  assign out_eol    = send && (k_q == K_LAST);
  assign out_eof    = send && (k_q == K_LAST) && (row_q == ROW_LAST);
  assign frame_done = (state_q == S_DONE);

endmodule

// File: tb/tb_life_frame_streamer.sv
// Bench for life_frame_streamer: 40x3 grid in 16-bit words, plus a 16x1 instance.
module tb_life_frame_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, start, busy, hold_gen, row_rd, out_valid, out_ready;
  logic        out_sof, out_eol, out_eof, frame_done;
  logic [1:0]  row_addr;
  logic [39:0] row_data;
  logic [15:0] out_data;

  logic        start1, busy1, hold1, rd1, valid1, sof1, eol1, eof1, done1;
  logic [0:0]  addr1;
  logic [15:0] rdata1, data1;

  life_frame_streamer #(.WIDTH(40), .HEIGHT(3), .WORD_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .hold_gen(hold_gen),
    .row_rd(row_rd), .row_addr(row_addr), .row_data(row_data), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof), .out_eol(out_eol),
    .out_eof(out_eof), .frame_done(frame_done));

  life_frame_streamer #(.WIDTH(16), .HEIGHT(1), .WORD_W(16)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .busy(busy1), .hold_gen(hold1),
    .row_rd(rd1), .row_addr(addr1), .row_data(rdata1), .out_data(data1),
    .out_valid(valid1), .out_ready(1'b1), .out_sof(sof1), .out_eol(eol1),
    .out_eof(eof1), .frame_done(done1));

  typedef struct {
    logic [39:0] row;
    logic [47:0] words;
    logic [2:0]  sof;
    logic [2:0]  eol;
    logic [2:0]  eof;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic        sof;
    logic        eol;
    logic        eof;
  } exp_t;

  vec_t        tbl[3];
  exp_t        sb[$];
  exp_t        e;
  logic [39:0] mem[3];
  logic [47:0] pad;
  bit          tbl_mode;

  int n_checks = 0, n_pass = 0;
  int cyc = 0, t0, fd_cnt = 0, fd_cyc = 0, rd_cnt = 0, exp_row = 0;
  int rd_first, vld_first, words_seen, f0;
  bit saw_rd, saw_vld, prev_rd, prev_stall, ok;
  logic [1:0]  prev_addr;
  logic [15:0] prev_data;
  logic [2:0]  prev_flags;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Row memory responder, scoreboard producer and stream monitor.
  always @(negedge clk) begin
    if (!reset_n) begin
      sb.delete();
      prev_rd    = 1'b0;
      prev_stall = 1'b0;
      exp_row    = 0;
      row_data   = '0;
    end else begin
      row_data = prev_rd ? mem[prev_addr] : 40'hDE_ADBE_EF00;
      if (row_rd) begin
        chk("row_addr", row_addr, exp_row);
        rd_cnt++;
        if (!saw_rd) begin rd_first = cyc; saw_rd = 1'b1; end
        pad = {8'h00, mem[row_addr]};
        for (int k = 0; k < 3; k++) begin
          if (tbl_mode) begin
            e.data = tbl[row_addr].words[k*16 +: 16];
            e.sof  = tbl[row_addr].sof[k];
            e.eol  = tbl[row_addr].eol[k];
            e.eof  = tbl[row_addr].eof[k];
          end else begin
            e.data = pad[k*16 +: 16];
            e.sof  = (row_addr == 2'd0) && (k == 0);
            e.eol  = (k == 2);
            e.eof  = (row_addr == 2'd2) && (k == 2);
          end
          sb.push_back(e);
        end
        exp_row++;
      end
      prev_rd   = row_rd;
      prev_addr = row_addr;

      if (prev_stall) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_hold", {out_data, out_sof, out_eol, out_eof}, {prev_data, prev_flags});
      end
      if (out_valid) begin
        if (!saw_vld) begin vld_first = cyc; saw_vld = 1'b1; end
        if (out_ready) begin
          if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL sb_underflow: unexpected word %0h, expected none", out_data);
          end else begin
            e = sb.pop_front();
            chk("word_data", out_data, e.data);
            chk("word_flags", {out_sof, out_eol, out_eof}, {e.sof, e.eol, e.eof});
          end
          words_seen++;
        end
      end else begin
        chk("idle_outputs", {out_data, out_sof, out_eol, out_eof}, '0);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_flags = {out_sof, out_eol, out_eof};
      if (frame_done) begin fd_cnt++; fd_cyc = cyc; exp_row = 0; end
    end
  end

  task automatic run_start();
    @(posedge clk); #1;
    saw_rd = 1'b0; saw_vld = 1'b0; words_seen = 0;
    start = 1'b1; t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_hold_gen", hold_gen, 1'b1);
    chk("start_row_rd", {row_rd, row_addr}, {1'b1, 2'd0});
  endtask

  task automatic wait_done(input int budget);
    int f = fd_cnt;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (fd_cnt > f) break;
    end
    chk("done_seen", fd_cnt > f, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{40'h00_FFFF_1234, 48'h0000_FFFF_1234, 3'b001, 3'b100, 3'b000};
    tbl[1] = '{40'hAA_0000_5555, 48'h00AA_0000_5555, 3'b000, 3'b100, 3'b000};
    tbl[2] = '{40'h80_0001_0001, 48'h0080_0001_0001, 3'b000, 3'b100, 3'b100};
    for (int i = 0; i < 3; i++) mem[i] = tbl[i].row;
    tbl_mode = 1'b1;
    reset_n = 1'b0; start = 1'b0; start1 = 1'b0; out_ready = 1'b1; rdata1 = 16'hC3A5;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", {busy, hold_gen, row_rd, frame_done, out_valid}, '0);
    chk("rst_data", {out_data, out_sof, out_eol, out_eof}, '0);
    chk("rst_dut1", {busy1, hold1, valid1, done1}, '0);
    reset_n = 1'b1;

    // Full frame from the table, free-flowing sink.
    run_start();
    wait_done(100);
    chk("lat_row_rd", rd_first, t0 + 1);
    chk("lat_valid", vld_first, t0 + 3);
    chk("lat_done", fd_cyc, t0 + 16);
    chk("words", words_seen, 9);
    chk("sb_empty", sb.size(), 0);
    @(posedge clk); #1;
    chk("idle_after", {busy, hold_gen, frame_done}, '0);

    // Back-pressure on the second word.
    run_start();
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (out_valid && words_seen == 1) begin ok = 1'b1; break; end
    end
    chk("bp_reach", {ok, out_data}, {1'b1, 16'hFFFF});
    out_ready = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("bp_held", {out_valid, out_data, words_seen}, {1'b1, 16'hFFFF, 32'd1});
    out_ready = 1'b1;
    wait_done(100);
    chk("bp_done", fd_cyc, t0 + 21);
    chk("bp_words", words_seen, 9);
    chk("bp_sb_empty", sb.size(), 0);

    // start while busy and while in DONE is dropped.
    f0 = fd_cnt; rd_cnt = 0;
    run_start();
    repeat (4) begin @(posedge clk); #1; end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (frame_done) break;
      @(posedge clk); #1;
    end
    chk("ign_in_done", frame_done, 1'b1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    chk("ign_frames", fd_cnt - f0, 1);
    chk("ign_reads", rd_cnt, 3);
    chk("ign_idle", {busy, hold_gen}, '0);

    // Reset in the middle of row 1, then a clean restart.
    run_start();
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (out_valid && words_seen == 4) begin ok = 1'b1; break; end
    end
    chk("rst_reach", ok, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("rst_abort", {out_valid, busy, hold_gen, row_rd, out_data}, '0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    run_start();
    wait_done(100);
    chk("rst_words", words_seen, 9);
    chk("rst_sb_empty", sb.size(), 0);

    // Random rows with a randomly stalling sink.
    tbl_mode = 1'b0;
    for (int i = 0; i < 3; i++) mem[i] = {$urandom_range(0, 255), $urandom()};
    run_start();
    f0 = fd_cnt;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 2) != 0);
      if (fd_cnt > f0) break;
    end
    out_ready = 1'b1;
    chk("rnd_done", fd_cnt > f0, 1'b1);
    chk("rnd_words", words_seen, 9);
    chk("rnd_sb_empty", sb.size(), 0);

    // Single-word, single-row instance.
    @(posedge clk); #1;
    start1 = 1'b1; t0 = cyc;
    @(posedge clk); #1;
    start1 = 1'b0;
    chk("w1_rd", {rd1, addr1, hold1}, {1'b1, 1'b0, 1'b1});
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (valid1) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("w1_valid_at", {ok, 32'(cyc)}, {1'b1, 32'(t0 + 3)});
    chk("w1_word", {data1, sof1, eol1, eof1}, {16'hC3A5, 3'b111});
    @(posedge clk); #1;
    chk("w1_done", {done1, valid1}, 2'b10);
    @(posedge clk); #1;
    chk("w1_idle", {busy1, done1, hold1}, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
